// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tracks the post-ID pipeline entries (EXE .. WB) and
// decides per cycle whether the ID instruction must stall (freeze) or be
// squashed by a taken branch (flush).
// Optional macro PIPE_FWD_EN: adds operand forwarding, so only load-use
// stalls remain, and exposes fwd_sel1/fwd_sel2 for the EXE instruction.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 3,
    parameter int REG_ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_W-1:0]     id_src1,
    input  logic [REG_ADDR_W-1:0]     id_src2,
    input  logic                      id_two_src,
    input  logic                      id_wb_en,
    input  logic                      id_mem_r_en,
    input  logic [REG_ADDR_W-1:0]     id_dest,
    input  logic                      branch_taken,
    output logic                      freeze,
    output logic                      flush,
`ifdef PIPE_FWD_EN
    output logic [$clog2(STAGES)-1:0] fwd_sel1,
    output logic [$clog2(STAGES)-1:0] fwd_sel2,
`endif
    output logic [STAGES-1:0]         stage_valid
);

    localparam int SEL_W = $clog2(STAGES);

    // Entry k: index 0 = EXE, STAGES-1 = WB.
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     wb_q;
    logic [STAGES-1:0]     mr_q;
    logic [REG_ADDR_W-1:0] dest_q [STAGES];

    logic [STAGES-2:0]     match1;
    logic [STAGES-2:0]     match2;
    logic                  hazard;
    logic                  load;

    // Compare ID sources against every producer that has not yet written the
    // register file; WB is skipped because the register file is write-through.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int j = 0; j < STAGES - 1; j++) begin
            match1[j] = valid_q[j] && wb_q[j] && (dest_q[j] == id_src1);
            match2[j] = valid_q[j] && wb_q[j] && (dest_q[j] == id_src2) && id_two_src;
        end
    end

`ifdef PIPE_FWD_EN
    logic [SEL_W-1:0] sel1_d;
    logic [SEL_W-1:0] sel2_d;
    logic [SEL_W-1:0] sel1_q;
    logic [SEL_W-1:0] sel2_q;

    // A load still in EXE has no result to bypass yet: that is the only stall.
    assign hazard = id_valid && mr_q[0] && (match1[0] || match2[0]);

    // Scan oldest to youngest so the youngest producer overwrites older ones.
    always_comb begin
        sel1_d = '0;
        sel2_d = '0;
        for (int j = STAGES - 2; j >= 0; j--) begin
            if (match1[j]) sel1_d = SEL_W'(j + 1);
            if (match2[j]) sel2_d = SEL_W'(j + 1);
        end
    end

    // Forward selects travel with the instruction into EXE; bubbles carry 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel1_q <= '0;
            sel2_q <= '0;
        end else begin
            sel1_q <= load ? sel1_d : '0;
            sel2_q <= load ? sel2_d : '0;
        end
    end

    assign fwd_sel1 = sel1_q;
    assign fwd_sel2 = sel2_q;
`else
    // Without bypassing, any in-flight producer of an active source stalls ID.
    assign hazard = id_valid && ((|match1) || (|match2));
`endif

    // A taken branch squashes ID, so it overrides any stall request.
    assign flush  = branch_taken;
    assign freeze = hazard && !branch_taken;
    assign load   = id_valid && !freeze && !flush;

    // Advance the tracking pipe; EXE gets the ID instruction or a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            wb_q    <= '0;
            mr_q    <= '0;
            for (int k = 0; k < STAGES; k++) dest_q[k] <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                wb_q[k]    <= wb_q[k-1];
                mr_q[k]    <= mr_q[k-1];
                dest_q[k]  <= dest_q[k-1];
            end
            valid_q[0] <= load;
            wb_q[0]    <= load && id_wb_en;
            mr_q[0]    <= load && id_mem_r_en;
            dest_q[0]  <= load ? id_dest : '0;
        end
    end

    assign stage_valid = valid_q;

    // Fields kept for a uniform entry layout but never consulted downstream.
    logic unused_fields;
    assign unused_fields = ^{mr_q, wb_q[STAGES-1], dest_q[STAGES-1]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the stage contents.
module tb_pipe_hazard_ctrl;

    localparam int STAGES = 3;
    localparam int W      = 4;
    localparam int SW     = $clog2(STAGES);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
    logic branch_taken = 1'b0;
    logic [W-1:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic freeze, flush;
    logic [STAGES-1:0] stage_valid;
`ifdef PIPE_FWD_EN
    logic [SW-1:0] fwd_sel1, fwd_sel2;
    logic [SW-1:0] s_sel1, s_sel2;
    bit m_mr [STAGES];
    int m_sel1 = 0, m_sel2 = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: what each stage holds, as plain values.
    bit m_valid [STAGES];
    bit m_wb    [STAGES];
    int m_dest  [STAGES];
    bit m_known = 1'b0;

    logic s_freeze, s_flush;
    logic [STAGES-1:0] s_sv;
    int stalls;

    pipe_hazard_ctrl #(.STAGES(STAGES), .REG_ADDR_W(W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .branch_taken(branch_taken), .freeze(freeze), .flush(flush),
`ifdef PIPE_FWD_EN
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
`endif
        .stage_valid(stage_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight producer of src that has not reached WB, or -1.
    function automatic int youngest(int src);
        for (int j = 0; j < STAGES - 1; j++)
            if (m_valid[j] && m_wb[j] && m_dest[j] == src) return j;
        return -1;
    endfunction

    task automatic step(bit v, int s1, int s2, bit two, bit wb, bit mr, int d, bit bt, bit r);
        int p1, p2;
        bit haz, exp_freeze, accept;
        logic [STAGES-1:0] ev;
        @(negedge clk);
        id_valid = v; id_src1 = s1[W-1:0]; id_src2 = s2[W-1:0]; id_two_src = two;
        id_wb_en = wb; id_mem_r_en = mr; id_dest = d[W-1:0]; branch_taken = bt; rst = r;
        p1 = youngest(s1);
        p2 = two ? youngest(s2) : -1;
`ifdef PIPE_FWD_EN
        haz = v && m_mr[0] && (p1 == 0 || p2 == 0);
`else
        haz = v && (p1 >= 0 || p2 >= 0);
`endif
        exp_freeze = haz && !bt;
        accept = v && !exp_freeze && !bt;
        for (int k = 0; k < STAGES; k++) ev[k] = m_valid[k];
        #1;
        s_freeze = freeze; s_flush = flush; s_sv = stage_valid;
`ifdef PIPE_FWD_EN
        s_sel1 = fwd_sel1; s_sel2 = fwd_sel2;
`endif
        if (m_known) begin
            chk("freeze", freeze, exp_freeze);
            chk("flush", flush, bt);
            chk("stage_valid", stage_valid, ev);
`ifdef PIPE_FWD_EN
            chk("fwd_sel1", fwd_sel1, m_sel1);
            chk("fwd_sel2", fwd_sel2, m_sel2);
`endif
        end
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < STAGES; k++) begin
                m_valid[k] = 0; m_wb[k] = 0; m_dest[k] = 0;
`ifdef PIPE_FWD_EN
                m_mr[k] = 0;
`endif
            end
`ifdef PIPE_FWD_EN
            m_sel1 = 0; m_sel2 = 0;
`endif
            m_known = 1'b1;
        end else begin
            for (int k = STAGES - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1]; m_wb[k] = m_wb[k-1]; m_dest[k] = m_dest[k-1];
`ifdef PIPE_FWD_EN
                m_mr[k] = m_mr[k-1];
`endif
            end
            m_valid[0] = accept;
            m_wb[0]    = accept && wb;
            m_dest[0]  = accept ? d : 0;
`ifdef PIPE_FWD_EN
            m_mr[0] = accept && mr;
            m_sel1  = (accept && p1 >= 0) ? p1 + 1 : 0;
            m_sel2  = (accept && p2 >= 0) ? p2 + 1 : 0;
`endif
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset, then confirm the cleared state.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_sv", s_sv, 0);
        chk("reset_freeze", s_freeze, 0);
        chk("reset_flush", s_flush, 0);

        // Dependent ALU op: ADD r1 then SUB src1=r1.
        step(1, 5, 6, 0, 1, 0, 1, 0, 1);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 6, 0, 1, 0, 7, 0, 1);
            if (!s_freeze) break;
            stalls++;
        end
        idle(1);
        chk("sv_after_sub", s_sv[0], 1);
`ifdef PIPE_FWD_EN
        chk("alu_stalls", stalls, 0);
        chk("alu_fwd_sel1", s_sel1, 1);
`else
        chk("alu_stalls", stalls, 2);
`endif

        // Load-use: LDR r2 then ADD src2=r2.
        idle(STAGES);
        step(1, 0, 0, 0, 1, 1, 2, 0, 1);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 9, 2, 1, 1, 0, 10, 0, 1);
            if (!s_freeze) break;
            stalls++;
        end
        idle(1);
`ifdef PIPE_FWD_EN
        chk("lu_stalls", stalls, 1);
        chk("lu_fwd_sel2", s_sel2, 2);
`else
        chk("lu_stalls", stalls, 2);
`endif

        // Branch taken during a stall.
        idle(STAGES);
        step(1, 0, 0, 0, 1, 1, 3, 0, 1);
        step(1, 3, 0, 0, 1, 0, 11, 0, 1);
        chk("br_pre_freeze", s_freeze, 1);
        step(1, 3, 0, 0, 1, 0, 11, 1, 1);
        chk("br_flush", s_flush, 1);
        chk("br_freeze", s_freeze, 0);
        idle(1);
        chk("br_bubble", s_sv[0], 0);

        // Second source ignored when id_two_src=0.
        idle(STAGES);
        step(1, 0, 0, 0, 1, 0, 4, 0, 1);
        step(1, 8, 4, 0, 1, 0, 12, 0, 1);
        chk("two_src_gate", s_freeze, 0);

        // Register 0 is an ordinary register.
        idle(STAGES);
        step(1, 0, 0, 0, 1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 13, 0, 1);
        chk("r0_hazard", s_freeze, 1);

        // Reset in the middle of a stall.
        idle(STAGES);
        step(1, 0, 0, 0, 1, 1, 5, 0, 1);
        step(1, 5, 0, 0, 1, 0, 14, 0, 1);
        chk("rs_pre_freeze", s_freeze, 1);
        step(1, 5, 0, 0, 1, 0, 14, 0, 0);
        step(1, 5, 0, 0, 1, 0, 14, 0, 1);
        chk("rs_sv", s_sv, 0);
        chk("rs_freeze", s_freeze, 0);
        idle(1);
        chk("rs_accept", s_sv, 1);

        // Random traffic on a small register set to provoke frequent hazards.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
